mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 64K-word instruction/data memory (rom64) of MIPSCORE16.
- Port m0 is instruction fetch and port m1 is data load/store.
- Serialises single-word read/write transactions onto the memory's wrrd/addr/wr_data/rd_data interface and returns a per-port acknowledge plus read data.
- Transactions are one at a time, with no pipelining across requests.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the MIPSCORE16 rom64 memory.
// Port m0 is instruction fetch and port m1 is data load/store. Transactions are
// serialised one at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break instead of
// fixed m0-over-m1 priority).
module mem_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_wrrd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy
);

    // Wait counter covers the legal read latency range 0..7.
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;        // 0 = m0 granted, 1 = m1 granted
    logic          wr_q, wr_d;          // latched write flag of the granted request
    logic          mem_wrrd_q, mem_wrrd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          busy_q, busy_d;
    logic          pick_m1;
    logic          done;

`ifdef ARB_ROUND_ROBIN_EN
    logic          prio_q, prio_d;      // 0 = favour m0, 1 = favour m1
`endif

    // Next-state, grant and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        mem_wrrd_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        done        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d      = prio_q;
        pick_m1     = m1_req & (~m0_req | prio_q);
`else
        pick_m1     = m1_req & ~m0_req;
`endif

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d       = pick_m1;
                    wr_d        = pick_m1 ? m1_wr    : m0_wr;
                    mem_addr_d  = pick_m1 ? m1_addr  : m0_addr;
                    mem_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                    mem_wrrd_d  = wr_d;
                    state_d     = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_d      = ~pick_m1;
`endif
                end
            end
            ISSUE: begin
                // Writes complete in the issue cycle; zero-latency reads capture here too.
                if (wr_q || (RD_LAT == 0)) begin
                    done = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion: ack the granted port and hand it read data for reads.
        if (done) begin
            state_d = RESP;
            if (gnt_q) begin
                m1_ack_d = 1'b1;
                if (!wr_q) begin
                    m1_rdata_d = mem_rd_data;
                end
            end else begin
                m0_ack_d = 1'b1;
                if (!wr_q) begin
                    m0_rdata_d = mem_rd_data;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_wrrd_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            mem_wrrd_q  <= mem_wrrd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer; reset favours m0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign mem_wrrd    = mem_wrrd_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes expected ack
// cycle and read data per port; a negedge monitor pops and compares on each ack.
// Two extra instances (RD_LAT=0 and RD_LAT=3) cover the latency builds.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack, mem_wrrd, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_addr;

    // Side instances for the latency builds.
    logic          z_req, t_req;
    logic [AW-1:0] s_addr;
    logic          z_ack, z_ack1, z_wrrd, z_busy, t_ack, t_ack1, t_wrrd, t_busy;
    logic [DW-1:0] z_rdata, z_rdata1, z_wd, z_rd, t_rdata, t_rdata1, t_wd, t_rd;
    logic [AW-1:0] z_maddr, t_maddr;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_wrrd(mem_wrrd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .m0_req(z_req), .m0_wr(1'b0), .m0_addr(s_addr), .m0_wdata(32'h0),
        .m0_ack(z_ack), .m0_rdata(z_rdata),
        .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(16'h0), .m1_wdata(32'h0),
        .m1_ack(z_ack1), .m1_rdata(z_rdata1),
        .mem_wrrd(z_wrrd), .mem_addr(z_maddr), .mem_wr_data(z_wd),
        .mem_rd_data(z_rd), .busy(z_busy)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .m0_req(t_req), .m0_wr(1'b0), .m0_addr(s_addr), .m0_wdata(32'h0),
        .m0_ack(t_ack), .m0_rdata(t_rdata),
        .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(16'h0), .m1_wdata(32'h0),
        .m1_ack(t_ack1), .m1_rdata(t_rdata1),
        .mem_wrrd(t_wrrd), .mem_addr(t_maddr), .mem_wr_data(t_wd),
        .mem_rd_data(t_rd), .busy(t_busy)
    );

    // Memory model: synchronous write, read delayed by an address pipeline per latency.
    logic [DW-1:0] mem [0:65535];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [AW-1:0] a1_q, t1_q, t2_q, t3_q;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wrrd) mem[mem_addr] <= mem_wr_data;
    end

    always @(posedge clk) begin
        a1_q <= mem_addr;
        t1_q <= t_maddr;
        t2_q <= t1_q;
        t3_q <= t2_q;
    end

    assign mem_rd_data = mem[a1_q];
    assign z_rd        = mem[z_maddr];
    assign t_rd        = mem[t3_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] rdata;
        int            cyc;      // negative: ack cycle not checked
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_pulses = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic prev_wrrd = 1'b0;
    int   busy_low = 0;
    int   b_m0 = 0;
    int   b_m1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ack(input bit port, input logic [DW-1:0] rd);
        exp_t e;
        if (port ? (q1.size() == 0) : (q0.size() == 0)) begin
            check(port ? "m1_spurious_ack" : "m0_spurious_ack", 64'd1, 64'd0);
            return;
        end
        e = port ? q1.pop_front() : q0.pop_front();
        if (e.cyc >= 0) check(port ? "m1_ack_cycle" : "m0_ack_cycle", 64'(cyc), 64'(e.cyc));
        check(port ? "m1_rdata" : "m0_rdata", 64'(rd), 64'(e.rdata));
    endtask

    // Monitor: compare every ack against the scoreboard, watch mem_wrrd width and busy.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m0_ack) begin chk_ack(1'b0, m0_rdata); b_m0 = busy_low; end
                if (m1_ack) begin chk_ack(1'b1, m1_rdata); b_m1 = busy_low; end
                if (mem_wrrd) begin
                    wr_pulses++;
                    last_wr_addr = mem_addr;
                    if (prev_wrrd) check("mem_wrrd_width", 64'd2, 64'd1);
                end
                prev_wrrd = mem_wrrd;
                if (!busy) busy_low++;
            end
        end
    end

    // One transaction on a port; call just after a posedge with the arbiter idle.
    // delay = expected ack cycle minus sampling edge, or -1 when contention makes it unchecked.
    task automatic txn(input bit port, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input int delay);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.cyc   = (delay < 0) ? -1 : cyc + 1 + delay;
        if (port) begin
            q1.push_back(e);
            m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            q0.push_back(e);
            m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(port ? m1_ack : m0_ack) && n < 200);
        if (n >= 200) check(port ? "m1_ack_timeout" : "m0_ack_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (port) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int wp;
        rst = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        z_req = 1'b0; t_req = 1'b0; s_addr = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero", 64'(|{m0_ack, m1_ack, m0_rdata, m1_rdata, mem_wrrd, mem_addr,
              mem_wr_data, busy, z_ack, z_ack1, z_rdata, z_rdata1, z_wrrd, z_maddr, z_wd, z_busy,
              t_ack, t_ack1, t_rdata, t_rdata1, t_wrrd, t_maddr, t_wd, t_busy}), 64'd0);
        preload(16'h0020, 32'hCCCC_DDDD);
        preload(16'h0030, 32'hEEEE_FFFF);
        preload(16'h0040, 32'hC001_C0DE);
        preload(16'h0050, 32'hBAAD_C0DE);
        preload(16'h0500, 32'h5555_0500);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: m1 write then readback; single mem_wrrd pulse at 0x0010.
        wp = wr_pulses;
        txn(1'b1, 1'b1, 16'h0010, 32'hAAAA_BBBB, 32'h0, 1);
        check("t1_wrrd_pulses", 64'(wr_pulses - wp), 64'd1);
        check("t1_wrrd_addr", 64'(last_wr_addr), 64'h0010);
        txn(1'b1, 1'b0, 16'h0010, 32'h0, 32'hAAAA_BBBB, 1 + L);
        check("t1_no_wrrd_on_read", 64'(wr_pulses - wp), 64'd1);

        // Test 6: RD_LAT=0 and RD_LAT=3 builds, read 0x0050.
        s_addr = 16'h0050;
        z_req = 1'b1; t0 = cyc; n = 0;
        do begin @(posedge clk); #1; n++; end while (!z_ack && n < 50);
        check("t6_lat0_ack_cycle", 64'(cyc), 64'(t0 + 2));
        check("t6_lat0_rdata", 64'(z_rdata), 64'hBAAD_C0DE);
        @(posedge clk); #1; z_req = 1'b0;
        t_req = 1'b1; t0 = cyc; n = 0;
        do begin @(posedge clk); #1; n++; end while (!t_ack && n < 50);
        check("t6_lat3_ack_cycle", 64'(cyc), 64'(t0 + 5));
        check("t6_lat3_rdata", 64'(t_rdata), 64'hBAAD_C0DE);
        @(posedge clk); #1; t_req = 1'b0;

        // Test 2: simultaneous reads, m0 wins, one idle cycle between the two.
        fork
            txn(1'b0, 1'b0, 16'h0020, 32'h0, 32'hCCCC_DDDD, 1 + L);
            txn(1'b1, 1'b0, 16'h0030, 32'h0, 32'hEEEE_FFFF, 4 + 2 * L);
        join
        check("t2_busy_gap", 64'(b_m1 - b_m0), 64'd1);

        // Test 3: both ports re-requesting for four transactions.
        fork
`ifdef ARB_ROUND_ROBIN_EN
            begin
                txn(1'b0, 1'b0, 16'h0020, 32'h0, 32'hCCCC_DDDD, 1 + L);
                txn(1'b0, 1'b0, 16'h0020, 32'h0, 32'hCCCC_DDDD, 4 + 2 * L);
            end
            begin
                txn(1'b1, 1'b0, 16'h0030, 32'h0, 32'hEEEE_FFFF, 4 + 2 * L);
                txn(1'b1, 1'b0, 16'h0030, 32'h0, 32'hEEEE_FFFF, 4 + 2 * L);
            end
`else
            begin
                repeat (4) txn(1'b0, 1'b0, 16'h0020, 32'h0, 32'hCCCC_DDDD, 1 + L);
            end
            txn(1'b1, 1'b0, 16'h0030, 32'h0, 32'hEEEE_FFFF, 13 + 5 * L);
`endif
        join

        // Test 4: m0 writes with interleaved m1 reads of 0x0500, then readback.
        fork
            for (int i = 0; i < 5; i++)
                txn(1'b0, 1'b1, 16'h0200 + 16'(i), 32'hA000_A000 + 32'(i), 32'hCCCC_DDDD, -1);
            repeat (5) txn(1'b1, 1'b0, 16'h0500, 32'h0, 32'h5555_0500, -1);
        join
        for (int i = 0; i < 5; i++)
            txn(1'b0, 1'b0, 16'h0200 + 16'(i), 32'h0, 32'hA000_A000 + 32'(i), 1 + L);

        // Test 5: reset during WAIT of an m1 read abandons it with no ack.
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0040;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_outputs_zero", 64'(|{m0_ack, m1_ack, m0_rdata, m1_rdata, mem_wrrd, mem_addr,
              mem_wr_data, busy}), 64'd0);
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            txn(1'b0, 1'b0, 16'h0040, 32'h0, 32'hC001_C0DE, 1 + L);
            txn(1'b1, 1'b0, 16'h0040, 32'h0, 32'hC001_C0DE, 4 + 2 * L);
        join

        repeat (4) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
